// File: rtl/vc32_switch_debounce.sv
// Two-flop synchroniser plus prescaled per-bit sample-history debouncer with registered rise/fall pulses.
// Latency 2 + (STABLE_TICKS-1)*TICK_COUNT + 1 .. 2 + STABLE_TICKS*TICK_COUNT clocks; no backpressure, outputs valid every cycle.
module vc32_switch_debounce #(
    parameter int                 WIDTH        = 8,
    parameter int                 CNT_W        = 24,
    parameter logic [CNT_W-1:0]   TICK_COUNT   = CNT_W'(250_000),
    parameter int                 STABLE_TICKS = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1'b1);

    logic [WIDTH-1:0]                    s1_q, s_q;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [WIDTH-1:0][STABLE_TICKS-1:0]  hist_q, hist_d;
    logic [WIDTH-1:0]                    db_q, db_d;
    logic [WIDTH-1:0]                    rise_q, rise_d;
    logic [WIDTH-1:0]                    fall_q, fall_d;

    assign tick    = ena && (cnt_q == CNT_LAST);
    assign db_out  = db_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = |(rise_q | fall_q);

    always_comb begin
        cnt_d  = cnt_q;
        hist_d = hist_q;
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        if (ena) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][STABLE_TICKS-2:0], s_q[i]};
                // Acceptance looks at the history including the sample taken on this edge.
                if ((&hist_d[i]) && !db_q[i]) begin
                    db_d[i]   = 1'b1;
                    rise_d[i] = 1'b1;
                end else if (!(|hist_d[i]) && db_q[i]) begin
                    db_d[i]   = 1'b0;
                    fall_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= RESET_VALUE;
            s_q    <= RESET_VALUE;
            cnt_q  <= '0;
            db_q   <= RESET_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                hist_q[i] <= {STABLE_TICKS{RESET_VALUE[i]}};
            end
        end else begin
            s1_q   <= raw_in;
            s_q    <= s1_q;
            cnt_q  <= cnt_d;
            hist_q <= hist_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

endmodule

// File: tb/tb_vc32_switch_debounce.sv
// Directed bench for vc32_switch_debounce with TICK_COUNT=4, STABLE_TICKS=3.
module tb_vc32_switch_debounce;

    localparam int T  = 4;
    localparam int ST = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] raw_in;
    logic [7:0] db_out, rise, fall;
    logic       changed, tick;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ph = 0;
    logic [7:0] seen_rise, seen_fall;
    int         n_evt;

    vc32_switch_debounce #(
        .WIDTH(8), .CNT_W(24), .TICK_COUNT(24'd4), .STABLE_TICKS(ST), .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in),
        .db_out(db_out), .rise(rise), .fall(fall), .changed(changed), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges; observation point is 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (ena && rst_n) ph = (ph + 1) % T;
            #1;
            seen_rise = seen_rise | rise;
            seen_fall = seen_fall | fall;
            if (changed) n_evt++;
        end
    endtask

    // Edges from a raw step to db_out update, given prescaler count c at the time of the step.
    function automatic int exp_lat(input int c);
        for (int j = 3; j < 3 + T; j++) begin
            if ((c + j - 1) % T == T - 1) return j + (ST - 1) * T;
        end
        return -2;
    endfunction

    task automatic wait_db(input logic [7:0] target, output int lat);
        lat = -1;
        for (int j = 1; j <= 80; j++) begin
            step(1);
            if (db_out == target) begin
                lat = j;
                break;
            end
        end
    endtask

    int lat, c, tick_off;

    initial begin
        seen_rise = '0; seen_fall = '0; n_evt = 0;
        rst_n = 1'b0; ena = 1'b1; raw_in = 8'hFF;

        step(3);
        chk("rst_db", db_out, 8'h00);
        chk("rst_rise", rise, 8'h00);
        chk("rst_fall", fall, 8'h00);
        chk("rst_changed", changed, 1'b0);
        chk("rst_tick", tick, 1'b0);
        raw_in = 8'h00;
        step(1);
        rst_n = 1'b1; ph = 0;

        for (int k = 0; k < 16; k++) begin
            chk("tick_phase", tick, (k % T == T - 1));
            step(1);
        end

        // clean rise then fall on bit 0
        raw_in = 8'h01; c = ph; seen_fall = '0;
        wait_db(8'h01, lat);
        chk("rise_lat", lat, exp_lat(c));
        chk("rise_pulse", rise, 8'h01);
        chk("rise_changed", changed, 1'b1);
        step(1);
        chk("rise_clear", rise, 8'h00);
        chk("rise_changed_clear", changed, 1'b0);
        chk("rise_no_fall", seen_fall, 8'h00);

        raw_in = 8'h00; c = ph;
        wait_db(8'h00, lat);
        chk("fall_lat", lat, exp_lat(c));
        chk("fall_pulse", fall, 8'h01);
        chk("fall_rise0", rise, 8'h00);
        chk("fall_changed", changed, 1'b1);
        step(1);
        chk("fall_clear", fall, 8'h00);

        // glitch: 6 cycles high on bit 1
        seen_rise = '0; seen_fall = '0;
        raw_in = 8'h02; step(6);
        raw_in = 8'h00; step(20);
        chk("glitch_db", db_out, 8'h00);
        chk("glitch_rise", seen_rise, 8'h00);

        // one sample per tick: 1,1,0,1,1
        for (int p = 0; p < 5; p++) begin
            raw_in = (p == 2) ? 8'h00 : 8'h02;
            step(T);
        end
        raw_in = 8'h00; step(20);
        chk("pattern_db", db_out, 8'h00);
        chk("pattern_evts", {seen_rise, seen_fall}, 16'h0000);

        // simultaneous multi-bit change
        raw_in = 8'h0F; c = ph;
        wait_db(8'h0F, lat);
        chk("sim0_lat", lat, exp_lat(c));
        chk("sim0_rise", rise, 8'h0F);
        step(3);
        raw_in = 8'hF0; c = ph; n_evt = 0;
        wait_db(8'hF0, lat);
        chk("sim_lat", lat, exp_lat(c));
        chk("sim_rise", rise, 8'hF0);
        chk("sim_fall", fall, 8'h0F);
        chk("sim_changed", changed, 1'b1);
        step(1);
        chk("sim_changed_clear", changed, 1'b0);
        chk("sim_evt_count", n_evt, 1);

        // enable freeze: edges 6..25 after the step are disabled
        raw_in = 8'h00; c = ph; lat = -1; tick_off = 0;
        for (int j = 1; j <= 100; j++) begin
            ena = !(j > 5 && j <= 25);
            step(1);
            if (!ena && tick) tick_off++;
            if (db_out == 8'h00) begin
                lat = j;
                break;
            end
        end
        ena = 1'b1;
        chk("freeze_lat", lat, exp_lat(c) + 20);
        chk("freeze_tick", tick_off, 0);
        chk("freeze_fall", fall, 8'hF0);

        // async reset while rise is high
        step(2);
        raw_in = 8'hFF;
        wait_db(8'hFF, lat);
        chk("pre_rst_rise", rise, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rise", rise, 8'h00);
        chk("arst_changed", changed, 1'b0);
        chk("arst_db", db_out, 8'h00);
        step(2);
        rst_n = 1'b1; ph = 0; n_evt = 0;
        wait_db(8'hFF, lat);
        chk("post_rst_lat", lat, exp_lat(0));
        chk("post_rst_rise", rise, 8'hFF);
        chk("post_rst_evts", n_evt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
